// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Front end for the stage-4 data memory. Two requesters share the single
// memory port:
//   port A : pipeline load/store unit (default winner)
//   port B : debug / program-loader port (forced ahead of A once starved)
// At most one access is granted per cycle. The winner's fields drive the
// memory directly. A small tag pipeline, READ_LATENCY deep, remembers which
// port issued each read so the result can be steered back when it emerges.
//
// Parameters
//   READ_LATENCY : cycles from grant to valid mem_read_value (tag depth)
//   STARVE_LIMIT : consecutive denied B cycles before B is forced (1..15)
//
// Ports
//   clock, reset_n                     : clock, async active-low reset
//   a_req/a_write/a_addr/a_be/a_wdata  : port A request fields
//   a_gnt, a_rvalid, a_rdata           : port A grant and read return
//   b_*                                : identical set for port B
//   mem_write, mem_addr, mem_write_to,
//   mem_write_value                    : memory drive (winner's fields)
//   mem_read_value                     : memory read data
//
// Handshake: a request transfers in the cycle where x_req && x_gnt. While
// x_req=1 and x_gnt=0 the requester holds every field stable. x_gnt is a
// combinational function of both req inputs and the registered starvation
// count, so a lone request is accepted in the cycle it is raised. x_rvalid
// is a one-cycle pulse with no back-pressure; x_rdata is only meaningful
// while x_rvalid=1.
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset_n,

  input  logic        a_req,
  input  logic        a_write,
  input  logic [31:0] a_addr,
  input  logic [3:0]  a_be,
  input  logic [31:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,

  input  logic        b_req,
  input  logic        b_write,
  input  logic [31:0] b_addr,
  input  logic [3:0]  b_be,
  input  logic [31:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,

  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_write_to,
  output logic [31:0] mem_write_value,
  input  logic [31:0] mem_read_value
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Tag encoding for the port field: 0 = A, 1 = B.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  logic [3:0]              starve_cnt;
  logic                    b_starved;
  logic [READ_LATENCY-1:0] tag_valid;
  logic [READ_LATENCY-1:0] tag_port;
  logic                    read_granted;

  assign b_starved = (starve_cnt == LIMIT);

  // ---------------------------------------------------------------------------
  // Arbitration. B wins when A is idle or when B has hit the starvation
  // limit; otherwise A wins. Grants are held low while reset is asserted so
  // that nothing reaches the memory during reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (reset_n) begin
      if (b_req && (b_starved || !a_req)) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory drive from the winner. Reads present a zero write mask so the
  // memory never sees stray byte enables. With no winner everything is 0;
  // the memory performs a harmless read of word 0 whose result is discarded
  // because no tag is issued for it.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_write       = 1'b0;
    mem_addr        = 32'h0;
    mem_write_to    = 4'b0000;
    mem_write_value = 32'h0;
    if (a_gnt) begin
      mem_write       = a_write;
      mem_addr        = a_addr;
      mem_write_to    = a_write ? a_be : 4'b0000;
      mem_write_value = a_wdata;
    end else if (b_gnt) begin
      mem_write       = b_write;
      mem_addr        = b_addr;
      mem_write_to    = b_write ? b_be : 4'b0000;
      mem_write_value = b_wdata;
    end
  end

  // Only granted reads produce a return; stores (including be=0) never do.
  assign read_granted = (a_gnt && !a_write) || (b_gnt && !b_write);

  // ---------------------------------------------------------------------------
  // Starvation counter: counts consecutive cycles where B asks and loses.
  // Saturates at the limit so the forced grant stays asserted until taken.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= 4'd0;
    end else if (b_req && !b_gnt) begin
      if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline. Stage 0 captures the current cycle's grant; the last stage
  // lines up with mem_read_value for that access. Clearing the valids on
  // reset drops any reads that were in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_port  <= '0;
    end else begin
      tag_valid[0] <= read_granted;
      tag_port[0]  <= b_gnt ? PORT_B : PORT_A;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_port[i]  <= tag_port[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Return path. Data is shared and unmasked; rvalid selects the owner.
  // ---------------------------------------------------------------------------
  assign a_rvalid = tag_valid[READ_LATENCY-1] && (tag_port[READ_LATENCY-1] == PORT_A);
  assign b_rvalid = tag_valid[READ_LATENCY-1] && (tag_port[READ_LATENCY-1] == PORT_B);
  assign a_rdata  = mem_read_value;
  assign b_rdata  = mem_read_value;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Directed bench for dmem_port_arbiter with a behavioural two-cycle data
// memory. Read responses are pushed as {expected cycle, expected data} into
// per-port queues when a read is granted; a monitor on the falling edge pops
// and compares whenever a_rvalid or b_rvalid is seen. Grants, memory drive
// and reset behaviour are compared inline by the stimulus.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  localparam int LAT = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clock;
  logic reset_n;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int cyc;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic        a_req, a_write, a_gnt, a_rvalid;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic [3:0]  a_be;
  logic        b_req, b_write, b_gnt, b_rvalid;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [3:0]  b_be;
  logic        mem_write;
  logic [31:0] mem_addr, mem_write_value, mem_read_value;
  logic [3:0]  mem_write_to;

  dmem_port_arbiter #(.READ_LATENCY(LAT), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_be(a_be),
    .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_be(b_be),
    .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_write_to(mem_write_to),
    .mem_write_value(mem_write_value), .mem_read_value(mem_read_value)
  );

  // ---------------------------------------------------------------------------
  // Memory model: writes land at the end of the grant cycle; reads register
  // the address, then the data, giving data in grant cycle + 2.
  // ---------------------------------------------------------------------------
  logic [31:0] mem [0:255];
  logic [7:0]  rd_idx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | i;
    mem[4] <= 32'hDEAD_BEEF;
    mem[8] <= 32'h1122_3344;
  end

  always @(posedge clock) begin
    if (mem_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_write_to[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_write_value[8*i +: 8];
      end
    end
    rd_idx         <= mem_addr[9:2];
    mem_read_value <= mem[rd_idx];
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [63:0] exp_a_q[$];
  logic [63:0] exp_b_q[$];
  int n_vec;
  int n_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: entries are {cycle, data}, so both latency and steering are checked.
  always @(negedge clock) begin
    if (a_rvalid) begin
      if (exp_a_q.size() == 0) check("a_rvalid_unexpected", 64'(a_rvalid), 64'd0);
      else check("a_rdata", {32'(cyc), a_rdata}, exp_a_q.pop_front());
    end
    if (b_rvalid) begin
      if (exp_b_q.size() == 0) check("b_rvalid_unexpected", 64'(b_rvalid), 64'd0);
      else check("b_rdata", {32'(cyc), b_rdata}, exp_b_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks. All tasks start and end 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Issue one access alone on a port; it must be granted in its first cycle.
  task automatic issue(input bit port_b, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata,
                       input bit expect_rd, input logic [31:0] exp_data);
    int waits;
    logic gnt;
    if (port_b) begin
      b_req = 1; b_write = wr; b_addr = addr; b_be = be; b_wdata = wdata;
    end else begin
      a_req = 1; a_write = wr; a_addr = addr; a_be = be; a_wdata = wdata;
    end
    waits = 0;
    forever begin
      @(negedge clock);
      gnt = port_b ? b_gnt : a_gnt;
      if (gnt || waits == 16) break;
      waits++;
      @(posedge clock); #1;
    end
    check(port_b ? "b_gnt_wait" : "a_gnt_wait", 64'(waits), 64'd0);
    if (gnt) begin
      check("mem_drive", {31'd0, mem_write, mem_addr, mem_write_to, mem_write_value},
            {31'd0, wr, addr, wr ? be : 4'b0000, wdata});
      if (expect_rd) begin
        if (port_b) exp_b_q.push_back({32'(cyc + LAT), exp_data});
        else        exp_a_q.push_back({32'(cyc + LAT), exp_data});
      end
    end
    @(posedge clock); #1;
    if (port_b) b_req = 0; else a_req = 0;
  endtask

  // Both ports request zero-mask stores every cycle; B must win only at b_idx.
  task automatic contend(input int n, input int b_idx);
    for (int i = 0; i < n; i++) begin
      a_req = 1; a_write = 1; a_addr = 32'h40; a_be = 4'b0000; a_wdata = 32'hA;
      b_req = 1; b_write = 1; b_addr = 32'h44; b_be = 4'b0000; b_wdata = 32'hB;
      @(negedge clock);
      check("contend_gnt", {62'd0, a_gnt, b_gnt}, (i == b_idx) ? 64'd1 : 64'd2);
      if (i == b_idx) check("contend_mem_addr", 64'(mem_addr), 64'h44);
      @(posedge clock); #1;
    end
  endtask

  task automatic check_reset_outs();
    @(negedge clock);
    check("reset_outs", {mem_addr, mem_write_value},  64'd0);
    check("reset_ctl",  {57'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_write, mem_write_to[0],
                         |mem_write_to}, 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    reset_n = 0;
    a_req = 1; a_write = 1; a_addr = 32'h55; a_be = 4'hF; a_wdata = 32'h77;
    b_req = 1; b_write = 0; b_addr = 32'h66; b_be = 4'hF; b_wdata = 32'h88;
    // Requests held high during reset must not reach the memory.
    check_reset_outs();
    check_reset_outs();
    @(posedge clock); #1;
    a_req = 0; b_req = 0;
    reset_n = 1;
    idle(1);

    // Single load on A.
    issue(0, 0, 32'h10, 4'h0, 32'h0, 1, 32'hDEAD_BEEF);
    idle(3);

    // Byte store then back-to-back load of the same word.
    issue(0, 1, 32'h20, 4'b0010, 32'h0000_AB00, 0, 32'h0);
    issue(0, 0, 32'h20, 4'h0, 32'h0, 1, 32'h1122_AB44);
    idle(3);

    // Zero-mask store on B changes nothing.
    issue(1, 1, 32'h10, 4'b0000, 32'hFFFF_FFFF, 0, 32'h0);
    issue(1, 0, 32'h10, 4'h0, 32'h0, 1, 32'hDEAD_BEEF);
    idle(3);

    // Starvation: A x4, B, A x4, B.
    contend(5, 4);
    contend(5, 4);
    a_req = 0; b_req = 0;
    idle(3);

    // Interleaved reads A, B, A, B in consecutive cycles.
    issue(0, 0, 32'h10, 4'h0, 32'h0, 1, 32'hDEAD_BEEF);
    issue(1, 0, 32'h20, 4'h0, 32'h0, 1, 32'h1122_AB44);
    issue(0, 0, 32'h24, 4'h0, 32'h0, 1, 32'h1000_0009);
    issue(1, 0, 32'h14, 4'h0, 32'h0, 1, 32'h1000_0005);
    idle(4);

    // Reset with B partly starved: counter must restart from 0.
    contend(3, -1);
    reset_n = 0;
    check_reset_outs();
    @(posedge clock); #1;
    reset_n = 1;
    contend(5, 4);
    a_req = 0; b_req = 0;
    idle(3);

    // Reset with a B read in flight: its return must be dropped.
    issue(1, 0, 32'h24, 4'h0, 32'h0, 0, 32'h0);
    reset_n = 0;
    a_req = 1; b_req = 1;
    check_reset_outs();
    check_reset_outs();
    check_reset_outs();
    @(posedge clock); #1;
    a_req = 0; b_req = 0;
    reset_n = 1;
    idle(4);
    issue(0, 0, 32'h14, 4'h0, 32'h0, 1, 32'h1000_0005);
    idle(4);

    check("a_queue_empty", 64'(exp_a_q.size()), 64'd0);
    check("b_queue_empty", 64'(exp_b_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester front end for the stage-4 data memory. The pipeline load/store unit (port A) and the debug/program-loader port (port B) share the single memory port. The block grants at most one access per cycle and steers each read result back to its originator after the memory's fixed two-cycle read latency. It sits between stage 4 and `data_memory` and drives that memory's `write`, `long_addr`, `write_to` and `write_value` inputs directly.

## Interface
- `READ_LATENCY`, 2: cycles from grant to valid `read_value`; sets the depth of the tag pipeline.
- `STARVE_LIMIT`, 4: consecutive denied cycles of B after which B is forced ahead of A (1..15).
- `clock` input 1: single clock; everything is on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `a_req` input 1: port A request, held until granted.
- `a_write` input 1: 1 = store, 0 = load.
- `a_addr` input 32: byte address; bits [1:0] are ignored by memory.
- `a_be` input 4: byte enables for stores; ignored for loads.
- `a_wdata` input 32: store data, already lane-aligned.
- `a_gnt` output 1: request accepted this cycle.
- `a_rvalid` output 1: `a_rdata` valid this cycle.
- `a_rdata` output 32: load result.
- `b_req`, `b_write`, `b_addr`, `b_be`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: identical set for port B.
- `mem_write` output 1, `mem_addr` output 32, `mem_write_to` output 4, `mem_write_value` output 32: drive memory.
- `mem_read_value` input 32: memory read data.

## Operation
- Handshake: a request transfers when `x_req && x_gnt` in the same cycle. The requester holds all fields stable while `x_req=1 && x_gnt=0`. Grants are combinational from the current `req` signals and the starvation state.
- Arbitration: at most one grant per cycle.
  - Default is fixed priority, A over B.
  - If `starve_cnt == STARVE_LIMIT` and `b_req=1`, B is granted and A is denied.
- `starve_cnt` (4-bit register):
  - Increments, saturating at `STARVE_LIMIT`, each cycle with `b_req && !b_gnt`.
  - Clears to 0 on `b_gnt` or when `b_req=0`.
- Memory drive (combinational from the winner):
  - `mem_write = winner.write`, `mem_addr = winner.addr`, `mem_write_value = winner.wdata`.
  - `mem_write_to = winner.be` for writes and 4'b0000 for reads.
  - With no winner, all memory outputs are 0, which the memory treats as a read of word 0; that result is never returned to anyone.
- Tag pipeline: a shift register `READ_LATENCY` deep carrying {valid, port}.
  - Stage 0 is loaded with {1, port} on a granted read and with {0, x} on a write or idle cycle.
- Return path:
  - The final stage's valid and port produce `a_rvalid` or `b_rvalid`.
  - `a_rdata` and `b_rdata` both equal `mem_read_value` unmasked; qualify with `rvalid`.
- Ordering: the memory executes accesses in grant order, so read-after-write and write-after-read to the same address in back-to-back cycles need no stall. A read granted the cycle after a write returns the new data.
- Stores with `be=4'b0000` are granted, change no memory contents and produce no `rvalid`.

## Timing
- Reset values (asynchronous, on `reset_n=0`):
  - Tag pipeline all invalid, `starve_cnt=0`.
  - `a_rvalid = b_rvalid = 0`.
  - While in reset, `a_gnt = b_gnt = 0` and all `mem_*` outputs are 0.
- Read latency: grant in cycle t gives `x_rvalid=1` in cycle t+`READ_LATENCY` (t+2 by default). Exactly one `rvalid` pulse per granted read.
- Throughput: one access per cycle, sustained across any mix of ports and reads/writes.
- Reset mid-operation: in-flight reads are dropped and no `rvalid` appears after reset release. A write granted up to two cycles before reset may still complete in memory, because memory is not reset.
- Simultaneous requests: A wins unless B is starved; `starve_cnt` reaches the limit after exactly `STARVE_LIMIT` denied cycles.

## Test plan
- **Single load, port A:** `a_req=1` for a read of 0x10, with memory word 4 = 0xDEADBEEF → `a_gnt` in cycle 0; `a_rvalid=1` with `a_rdata=0xDEADBEEF` in cycle 2; `b_rvalid` stays 0.
- **Byte store then load:** A writes `be=4'b0010`, `wdata=0x0000AB00` to 0x20 (old word 0x11223344), then reads 0x20 the next cycle → `rvalid` 2 cycles after the read grant with data 0x1122AB44.
- **Starvation:** A and B both request continuously with `STARVE_LIMIT=4` → A is granted cycles 0–3, B in cycle 4, A cycles 5–8, B in cycle 9.
- **Interleaved reads:** reads granted A, B, A, B in cycles 0–3 → `rvalid` on A, B, A, B in cycles 2–5, each with the correct word.
- **Reset mid-flight:** B read granted in cycle 0, `reset_n` low in cycle 1 → no `b_rvalid` ever, all outputs 0 during reset; after release `starve_cnt=0` and the first request is granted immediately.
